// File: rtl/data_sender.sv
// Word-to-byte serialiser for a byte-oriented transmitter: offers one byte of a
// captured word at a time, LSB byte first, advancing on each transmission_done.
module data_sender #(
  parameter int NUM_BYTES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] dataIn,
  input  logic                   transmission_started,
  input  logic                   transmission_done,
  output logic [7:0]             dataOut,
  output logic                   all_bytes_sent
);

  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE,
    SENDING
  } state_t;

  state_t                 state, state_n;
  logic [8*NUM_BYTES-1:0] shadow, shadow_n;
  logic [IW-1:0]          idx, idx_n;
  logic                   sent_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shadow         <= '0;
      idx            <= '0;
      all_bytes_sent <= 1'b0;
    end else begin
      state          <= state_n;
      shadow         <= shadow_n;
      idx            <= idx_n;
      all_bytes_sent <= sent_n;
    end
  end

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    idx_n    = idx;
    sent_n   = 1'b0;
    case (state)
      IDLE: begin
        // Track dataIn continuously so the first byte is ready when TX starts.
        shadow_n = dataIn;
        idx_n    = '0;
        if (transmission_started) state_n = SENDING;
      end
      SENDING: begin
        if (transmission_done) begin
          if (idx == LAST) begin
            // Preload the next word and keep streaming without a new start.
            shadow_n = dataIn;
            idx_n    = '0;
            sent_n   = 1'b1;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign dataOut = shadow[8*idx +: 8];

endmodule

// File: tb/tb_data_sender.sv
// Scoreboard bench for data_sender: directed spec scenarios plus random traffic,
// checked each cycle against a word/byte-number reference model.
module tb_data_sender;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [39:0]   dataIn = '0;
  logic          transmission_started = 1'b0;
  logic          transmission_done = 1'b0;
  logic [7:0]    dataOut;
  logic          all_bytes_sent;

  data_sender #(.NUM_BYTES(NB)) dut (
    .clk(clk),
    .rst(rst),
    .dataIn(dataIn),
    .transmission_started(transmission_started),
    .transmission_done(transmission_done),
    .dataOut(dataOut),
    .all_bytes_sent(all_bytes_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       a;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the word being sent, how many bytes of it are done,
  // whether a transfer is in progress, and the completion flag.
  logic [39:0] m_word = '0;
  int          m_n = 0;
  bit          m_send = 0;
  logic        m_abs = 1'b0;
  logic [39:0] din = '0;

  task automatic model(input logic r, input logic [39:0] d, input logic s, input logic n);
    m_abs = 1'b0;
    if (r) begin
      m_word = '0; m_n = 0; m_send = 0;
    end else if (!m_send) begin
      m_word = d; m_n = 0;
      if (s) m_send = 1;
    end else if (n) begin
      if (m_n == NB - 1) begin
        m_word = d; m_n = 0; m_abs = 1'b1;
      end else begin
        m_n = m_n + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [39:0] d, input logic s, input logic n);
    exp_t e;
    @(negedge clk);
    rst = r; dataIn = d; transmission_started = s; transmission_done = n;
    @(posedge clk);
    model(r, d, s, n);
    e.b = 8'(m_word >> (8 * m_n));
    e.a = m_abs;
    q.push_back(e);
  endtask

  // Constant expectation taken straight from the worked examples.
  task automatic cexp(input string name, input logic [7:0] b, input logic a);
    #1;
    checks++;
    if (dataOut !== b || all_bytes_sent !== a) begin
      errors++;
      $display("FAIL %s: dataOut=%h all_bytes_sent=%b, expected dataOut=%h all_bytes_sent=%b",
               name, dataOut, all_bytes_sent, b, a);
    end
  endtask

  task automatic reset_dut();
    step(1'b1, din, 1'b0, 1'b0);
  endtask
  task automatic start();
    step(1'b0, din, 1'b1, 1'b0);
  endtask
  task automatic done();
    step(1'b0, din, 1'b0, 1'b1);
  endtask
  task automatic gap();
    step(1'b0, din, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (dataOut !== e.b) begin
          errors++;
          $display("FAIL sb_dataOut @%0t: got %h, expected %h", $time, dataOut, e.b);
        end
        checks++;
        if (all_bytes_sent !== e.a) begin
          errors++;
          $display("FAIL sb_all_bytes_sent @%0t: got %b, expected %b", $time, all_bytes_sent, e.a);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] exp_seq[5];

    // Basic order
    din = 40'h1122334455;
    reset_dut(); cexp("reset", 8'h00, 1'b0);
    start();     cexp("basic_b0", 8'h55, 1'b0);
    exp_seq = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    for (int unsigned i = 0; i < 4; i++) begin
      done(); cexp("basic_next", exp_seq[i], 1'b0);
      gap();
    end

    // Freeze, then preload of the next word on the final done
    din = 40'h1122334455;
    reset_dut();
    start(); cexp("freeze_b0", 8'h55, 1'b0);
    din = 40'h123456789a;
    gap();   cexp("freeze_hold", 8'h55, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      done(); cexp("freeze_next", exp_seq[i], 1'b0);
    end
    done(); cexp("freeze_wrap", 8'h9a, 1'b1);
    gap();  cexp("freeze_pulse_end", 8'h9a, 1'b0);
    exp_seq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
    for (int unsigned i = 0; i < 4; i++) begin
      done(); cexp("word2_next", exp_seq[i], 1'b0);
    end

    // Repeated started pulses (and one coinciding with done) are ignored
    din = 40'h1122334455;
    reset_dut();
    start();
    exp_seq = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    for (int unsigned i = 0; i < 4; i++) begin
      start(); cexp("rep_started", (i == 0) ? 8'h55 : exp_seq[i-1], 1'b0);
      if (i == 2) step(1'b0, din, 1'b1, 1'b1);
      else        done();
      cexp("rep_next", exp_seq[i], 1'b0);
    end

    // Completion with dataIn changed mid-word
    din = 40'h1122334455;
    reset_dut();
    start();
    din = 40'h1122334456;
    for (int unsigned i = 0; i < 4; i++) done();
    cexp("compl_last", 8'h11, 1'b0);
    done(); cexp("compl_pulse", 8'h56, 1'b1);
    gap();  cexp("compl_after", 8'h56, 1'b0);

    // Reset mid-word
    din = 40'h1122334455;
    reset_dut();
    start(); done(); done(); cexp("mid_b2", 8'h33, 1'b0);
    reset_dut(); cexp("mid_reset", 8'h00, 1'b0);
    din = 40'haabbccddee;
    start(); cexp("mid_restart", 8'hee, 1'b0);
    done();  cexp("mid_restart_b1", 8'hdd, 1'b0);

    // Done in IDLE does not advance the index
    reset_dut();
    din = 40'h0102030405;
    done(); cexp("idle_done_a", 8'h05, 1'b0);
    din = 40'h0a0b0c0d0e;
    done(); cexp("idle_done_b", 8'h0e, 1'b0);
    start(); cexp("idle_then_start", 8'h0e, 1'b0);
    done();  cexp("idle_then_b1", 8'h0d, 1'b0);

    // Random traffic against the model
    for (int unsigned i = 0; i < 3000; i++) begin
      din = 40'({$urandom, $urandom});
      step(($urandom_range(0, 59) == 0), din,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
    end
    gap();

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
